cache_mem_arbiter: RTL and testbench
====================================

# cache_mem_arbiter

Two-port arbiter that shares one external memory bus between two cache controllers: port 0 for the instruction cache and port 1 for the data cache. Each port uses the same level-held rd_en/wr_en + single-cycle ack handshake that the cache controllers drive for Allocate/WriteBack. The block registers a grant, forwards the granted port's request to memory unchanged, and routes mem_ack and read data back only to that port. It sits between the two caches and the memory/bus interface.

## Interface
- ADDR_SIZE, 32, address width
- DATA_SIZE, 64, data width; BYTE_NUM = DATA_SIZE/8 (localparam)
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req0_rd_en / req1_rd_en  in  1  read request, held until ack
- req0_wr_en / req1_wr_en  in  1  write request, held until ack
- req0_sel / req1_sel  in  BYTE_NUM  byte enables
- req0_addr / req1_addr  in  ADDR_SIZE  request address
- req0_wr_data / req1_wr_data  in  DATA_SIZE  write data
- req0_rd_data / req1_rd_data  out  DATA_SIZE  read data (mem_rd_data when granted, else 0)
- req0_ack / req1_ack  out  1  completion pulse to the requester
- mem_rd_en, mem_wr_en  out  1  forwarded enables
- mem_sel  out  BYTE_NUM; mem_addr  out  ADDR_SIZE; mem_wr_data  out  DATA_SIZE
- mem_rd_data  in  DATA_SIZE; mem_ack  in  1  memory completion pulse
- grant  out  2  one-hot current owner (bit i = port i), 00 when idle

## Operation
- States: Idle, Grant0, Grant1. Register last_owner (1 bit).
- Port i requests when reqi_rd_en | reqi_wr_en.
- Idle: no request -> stay. One request -> GrantI. Both -> resolved by the tie-break rule (Configuration); last_owner updates on entry to the grant state.
- GrantI: mem_rd_en/mem_wr_en/mem_sel/mem_addr/mem_wr_data = port i's inputs combinationally. If port i has both enables set, only mem_wr_en is driven. reqi_ack = mem_ack, reqi_rd_data = mem_rd_data; other port's ack = 0, rd_data = 0.
- GrantI with mem_ack = 1 -> Idle.
- GrantI with port i dropping both enables before ack (abandon) -> Idle next cycle; mem enables fall the same cycle.
- Idle: all mem_* outputs 0; a mem_ack here is ignored, and no req ack is produced.
- Non-granted requests are held off with no ack and have no side effects.

## Timing
- Reset (async) values: state Idle, last_owner = 1, grant = 00, all mem_* outputs 0, all req acks 0, all req rd_data 0. Asserting reset mid-transaction drops the mem enables immediately, and the transaction is lost.
- Arbitration latency: request first seen high in Idle at cycle N -> grant and mem enables high at N+1.
- Ack is combinational: mem_ack at cycle M -> reqi_ack at cycle M, Idle at M+1. The earliest following grant drives the bus at M+2, which gives one bubble cycle between owners and after every transaction.
- A zero-wait memory (mem_ack in the first granted cycle) yields 2 cycles per transaction.
- A requester must hold its inputs stable from request until ack. The arbiter does not latch address or data.

## Configuration
- ROUND_ROBIN_EN defined: on a tie in Idle, grant goes to the port that is not last_owner. Two continuously requesting ports alternate 0,1,0,1…, and the first tie after reset goes to port 0.
- ROUND_ROBIN_EN undefined: fixed priority, port 0 always wins ties. last_owner is still maintained but unused, and port 1 can starve.

## Test plan
- Single read, port 0: req0_rd_en=1, addr 0x100 at cycle 0; memory acks at cycle 3 with data 0xDEADBEEF_CAFEF00D -> mem_rd_en high in cycles 1–3 with mem_addr 0x100, req0_ack=1 and req0_rd_data correct in cycle 3, grant=00 in cycle 4, req1_ack never asserted.
- Simultaneous requests, both held, zero-wait memory: ROUND_ROBIN_EN -> grants 01,00,10,00,01 (ports 0,1,0 with bubbles). Undefined -> port 0 granted every transaction and req1_ack stays 0.
- Write pass-through, port 1: wr_en, sel=0x0F, wr_data=0x1234 -> mem_wr_en=1, mem_sel=0x0F, mem_wr_data=0x1234 while granted, mem_rd_en=0.
- Both enables on port 0 -> only mem_wr_en asserted.
- Abandon: port 1 granted, drops enables before ack -> Idle next cycle, no req1_ack.
- Reset at cycle 2 of a granted read -> mem_rd_en=0 and grant=00 the same cycle. A stray mem_ack in Idle produces no req ack.

Source files
------------

// File: rtl/cache_mem_arbiter_if.sv
// cache_mem_arbiter_if: level-held rd_en/wr_en request bus with single-cycle ack
interface cache_mem_arbiter_if #(parameter int ADDR_SIZE = 32, parameter int DATA_SIZE = 64);
  localparam int BYTE_NUM = DATA_SIZE / 8;
  logic                 rd_en;
  logic                 wr_en;
  logic [BYTE_NUM-1:0]  sel;
  logic [ADDR_SIZE-1:0] addr;
  logic [DATA_SIZE-1:0] wr_data;
  logic [DATA_SIZE-1:0] rd_data;
  logic                 ack;
  modport master (output rd_en, wr_en, sel, addr, wr_data, input rd_data, ack);
  modport slave  (input rd_en, wr_en, sel, addr, wr_data, output rd_data, ack);
endinterface

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one memory bus between icache (port 0) and dcache (port 1); define ROUND_ROBIN_EN for round-robin ties, else port 0 wins
module cache_mem_arbiter #(
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  cache_mem_arbiter_if.slave    req0,
  cache_mem_arbiter_if.slave    req1,
  cache_mem_arbiter_if.master   mem,
  output logic [1:0]            grant
);
  localparam int BYTE_NUM = DATA_SIZE / 8;
  localparam logic [1:0] IDLE = 2'd0, GRANT0 = 2'd1, GRANT1 = 2'd2;
  logic [1:0] state, next_state;
  logic last_owner, r0, r1, pick1, g0, g1, rd_en, wr_en;
  logic [BYTE_NUM-1:0] sel;
  logic [ADDR_SIZE-1:0] addr;
  logic [DATA_SIZE-1:0] wr_data;
  assign r0 = req0.rd_en | req0.wr_en;
  assign r1 = req1.rd_en | req1.wr_en;
`ifdef ROUND_ROBIN_EN
  assign pick1 = r1 & (~r0 | ~last_owner);
`else
  assign pick1 = r1 & ~r0;
`endif
  assign g0 = state == GRANT0;
  assign g1 = state == GRANT1;
  assign grant = {g1, g0};
  // next owner: arbitrate from idle, release on ack or abandon
  always_comb begin
    next_state = state == IDLE   ? ((r0 | r1) ? (pick1 ? GRANT1 : GRANT0) : IDLE) :
                 state == GRANT0 ? ((mem.ack | ~r0) ? IDLE : GRANT0) :
                 state == GRANT1 ? ((mem.ack | ~r1) ? IDLE : GRANT1) : IDLE;
  end
  // state and last_owner, which changes only when a grant is taken
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= 1'b1;
    end else begin
      state      <= next_state;
      last_owner <= (state == IDLE && (r0 | r1)) ? pick1 : last_owner;
    end
  end
  // forward the owner's request; a write wins when both enables are set
  always_comb begin
    wr_en   = (g0 & req0.wr_en) | (g1 & req1.wr_en);
    rd_en   = (g0 & req0.rd_en & ~req0.wr_en) | (g1 & req1.rd_en & ~req1.wr_en);
    sel     = g0 ? req0.sel : g1 ? req1.sel : '0;
    addr    = g0 ? req0.addr : g1 ? req1.addr : '0;
    wr_data = g0 ? req0.wr_data : g1 ? req1.wr_data : '0;
  end
  assign mem.rd_en   = rd_en;
  assign mem.wr_en   = wr_en;
  assign mem.sel     = sel;
  assign mem.addr    = addr;
  assign mem.wr_data = wr_data;
  assign req0.ack     = g0 & mem.ack;
  assign req1.ack     = g1 & mem.ack;
  assign req0.rd_data = g0 ? mem.rd_data : '0;
  assign req1.rd_data = g1 ? mem.rd_data : '0;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: scoreboard bench for the two-port cache memory arbiter
module tb_cache_mem_arbiter;
  logic clock, reset;
  logic [1:0] grant;
  int checks = 0, failures = 0;
  typedef struct {
    logic [1:0]  g;
    logic        a0, a1;
    logic [63:0] d0, d1;
  } exp_t;
  exp_t sb[$];
  cache_mem_arbiter_if #(.ADDR_SIZE(32), .DATA_SIZE(64)) req0_if();
  cache_mem_arbiter_if #(.ADDR_SIZE(32), .DATA_SIZE(64)) req1_if();
  cache_mem_arbiter_if #(.ADDR_SIZE(32), .DATA_SIZE(64)) mem_if();
  cache_mem_arbiter #(.ADDR_SIZE(32), .DATA_SIZE(64)) dut (
    .clock(clock), .reset(reset), .req0(req0_if), .req1(req1_if), .mem(mem_if), .grant(grant)
  );
  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic push(input logic [1:0] g, input logic a0, input logic a1, input logic [63:0] d0, input logic [63:0] d1);
    exp_t e;
    e.g = g; e.a0 = a0; e.a1 = a1; e.d0 = d0; e.d1 = d1;
    sb.push_back(e);
  endtask
  task automatic observe(input string tag);
    exp_t e;
    check({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check({tag, "_grant"}, 64'(grant), 64'(e.g));
    check({tag, "_ack0"}, 64'(req0_if.ack), 64'(e.a0));
    check({tag, "_ack1"}, 64'(req1_if.ack), 64'(e.a1));
    check({tag, "_rd0"}, req0_if.rd_data, e.d0);
    check({tag, "_rd1"}, req1_if.rd_data, e.d1);
  endtask
  task automatic clear_inputs();
    req0_if.rd_en = 0; req0_if.wr_en = 0; req0_if.sel = '0; req0_if.addr = '0; req0_if.wr_data = '0;
    req1_if.rd_en = 0; req1_if.wr_en = 0; req1_if.sel = '0; req1_if.addr = '0; req1_if.wr_data = '0;
    mem_if.ack = 0; mem_if.rd_data = '0;
  endtask
  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
    #1;
  endtask
  task automatic check_mem_idle(input string tag);
    check({tag, "_mem_rd"}, 64'(mem_if.rd_en), 0);
    check({tag, "_mem_wr"}, 64'(mem_if.wr_en), 0);
    check({tag, "_mem_addr"}, 64'(mem_if.addr), 0);
    check({tag, "_mem_sel"}, 64'(mem_if.sel), 0);
    check({tag, "_mem_wdata"}, mem_if.wr_data, 0);
  endtask
  logic [1:0] rr_seq [5];
  initial begin
    clear_inputs();
    reset = 1;
    #2;
    push(2'b00, 0, 0, 0, 0);
    observe("reset");
    check_mem_idle("reset");
    tick();
    reset = 0;
    tick();
    // single read on port 0 with three-cycle memory latency
    req0_if.rd_en = 1; req0_if.addr = 32'h100; req0_if.sel = 8'hFF;
    #1;
    push(2'b00, 0, 0, 0, 0);
    observe("rd_c0");
    for (int c = 1; c <= 2; c++) begin
      tick();
      push(2'b01, 0, 0, 0, 0);
      observe($sformatf("rd_c%0d", c));
      check("rd_mem_rd", 64'(mem_if.rd_en), 1);
      check("rd_mem_addr", 64'(mem_if.addr), 64'h100);
    end
    tick();
    mem_if.rd_data = 64'hDEADBEEF_CAFEF00D; mem_if.ack = 1;
    #1;
    push(2'b01, 1, 0, 64'hDEADBEEF_CAFEF00D, 0);
    observe("rd_c3");
    check("rd_c3_mem_rd", 64'(mem_if.rd_en), 1);
    tick();
    mem_if.ack = 0; req0_if.rd_en = 0;
    #1;
    push(2'b00, 0, 0, 0, 0);
    observe("rd_c4");
    check_mem_idle("rd_c4");
    // two held requesters against a zero-wait memory
    do_reset();
`ifdef ROUND_ROBIN_EN
    rr_seq = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
`else
    rr_seq = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
`endif
    req0_if.rd_en = 1; req0_if.addr = 32'h40;
    req1_if.rd_en = 1; req1_if.addr = 32'h80;
    mem_if.ack = 1; mem_if.rd_data = 64'h55;
    for (int k = 0; k < 5; k++)
      push(rr_seq[k], rr_seq[k][0], rr_seq[k][1], rr_seq[k][0] ? 64'h55 : 64'h0, rr_seq[k][1] ? 64'h55 : 64'h0);
    #1;
    check("tie_c0_grant", 64'(grant), 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      observe($sformatf("tie_c%0d", k + 1));
      check($sformatf("tie_c%0d_addr", k + 1), 64'(mem_if.addr), rr_seq[k] == 2'b01 ? 64'h40 : rr_seq[k] == 2'b10 ? 64'h80 : 64'h0);
    end
    req0_if.rd_en = 0; req1_if.rd_en = 0; mem_if.ack = 0;
    tick();
    // write pass-through on port 1
    do_reset();
    req1_if.wr_en = 1; req1_if.sel = 8'h0F; req1_if.wr_data = 64'h1234; req1_if.addr = 32'h200;
    tick();
    push(2'b10, 0, 0, 0, 0);
    observe("wr_grant");
    check("wr_mem_wr", 64'(mem_if.wr_en), 1);
    check("wr_mem_rd", 64'(mem_if.rd_en), 0);
    check("wr_mem_sel", 64'(mem_if.sel), 64'h0F);
    check("wr_mem_wdata", mem_if.wr_data, 64'h1234);
    check("wr_mem_addr", 64'(mem_if.addr), 64'h200);
    mem_if.ack = 1;
    #1;
    push(2'b10, 0, 1, 0, 0);
    observe("wr_ack");
    tick();
    mem_if.ack = 0; req1_if.wr_en = 0;
    #1;
    push(2'b00, 0, 0, 0, 0);
    observe("wr_done");
    // both enables on port 0: only the write is forwarded
    req0_if.rd_en = 1; req0_if.wr_en = 1; req0_if.addr = 32'h300;
    tick();
    check("both_grant", 64'(grant), 64'(2'b01));
    check("both_mem_wr", 64'(mem_if.wr_en), 1);
    check("both_mem_rd", 64'(mem_if.rd_en), 0);
    mem_if.ack = 1;
    #1;
    check("both_ack0", 64'(req0_if.ack), 1);
    tick();
    mem_if.ack = 0; req0_if.rd_en = 0; req0_if.wr_en = 0;
    tick();
    // port 1 abandons before ack
    req1_if.rd_en = 1; req1_if.addr = 32'h400;
    tick();
    check("abn_grant", 64'(grant), 64'(2'b10));
    check("abn_mem_rd", 64'(mem_if.rd_en), 1);
    req1_if.rd_en = 0;
    #1;
    check("abn_mem_rd_drop", 64'(mem_if.rd_en), 0);
    check("abn_ack1", 64'(req1_if.ack), 0);
    tick();
    check("abn_idle", 64'(grant), 0);
    // a stray ack while idle is ignored
    mem_if.ack = 1; mem_if.rd_data = 64'h77;
    #1;
    push(2'b00, 0, 0, 0, 0);
    observe("stray");
    tick();
    check("stray_idle", 64'(grant), 0);
    mem_if.ack = 0;
    // reset in the middle of a granted read
    req0_if.rd_en = 1; req0_if.addr = 32'h500;
    tick();
    tick();
    check("rst_mid_grant", 64'(grant), 64'(2'b01));
    reset = 1;
    #1;
    check("rst_mid_mem_rd", 64'(mem_if.rd_en), 0);
    check("rst_mid_grant0", 64'(grant), 0);
    check("rst_mid_ack0", 64'(req0_if.ack), 0);
    tick();
    clear_inputs();
    reset = 0;
    tick();
    check("sb_drained", 64'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
